// File: rtl/stable_cnt_unit_pkg.sv
// Shared encodings and types for the rdcnt stable-counter service.
// Op-select encodings used by the decoder to drive req_sel.
package stable_cnt_unit_pkg;

    typedef enum logic [1:0] {
        RDCNT_SEL_VL  = 2'b00,
        RDCNT_SEL_VH  = 2'b01,
        RDCNT_SEL_ID  = 2'b10,
        RDCNT_SEL_INV = 2'b11
    } rdcnt_sel_e;

    localparam int RSP_W = 32;

endpackage

// File: rtl/stable_cnt_unit_port.sv
// One rdcnt read channel: valid/ready handshake, registered response and data mux.
// Optional per-channel high-half snapshot when STABLE_CNT_SNAPSHOT_EN is defined.
module stable_cnt_port
    import stable_cnt_unit_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [63:0]      cnt,
    input  logic [31:0]      tid,
    input  logic             req_valid,
    input  rdcnt_sel_e       req_sel,
    output logic             req_ready,
    output logic             rsp_valid,
    output logic [RSP_W-1:0] rsp_data,
    output logic             rsp_err,
    input  logic             rsp_ready
);

    logic             rsp_valid_q, rsp_valid_d;
    logic [RSP_W-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             accept;
`ifdef STABLE_CNT_SNAPSHOT_EN
    logic [31:0]      snap_hi_q, snap_hi_d;
    logic             snap_vld_q, snap_vld_d;
`endif

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign accept    = req_valid && req_ready;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
`ifdef STABLE_CNT_SNAPSHOT_EN
        snap_hi_d   = snap_hi_q;
        snap_vld_d  = snap_vld_q;
`endif
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            case (req_sel)
                RDCNT_SEL_VL: begin
                    rsp_data_d = cnt[31:0];
`ifdef STABLE_CNT_SNAPSHOT_EN
                    snap_hi_d  = cnt[63:32];
                    snap_vld_d = 1'b1;
`endif
                end
                RDCNT_SEL_VH: begin
`ifdef STABLE_CNT_SNAPSHOT_EN
                    // A pending snapshot keeps the VL/VH pair coherent across a low-half carry.
                    rsp_data_d = snap_vld_q ? snap_hi_q : cnt[63:32];
                    snap_vld_d = 1'b0;
`else
                    rsp_data_d = cnt[63:32];
`endif
                end
                RDCNT_SEL_ID: rsp_data_d = tid;
                default: begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                end
            endcase
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
`ifdef STABLE_CNT_SNAPSHOT_EN
            snap_hi_q   <= '0;
            snap_vld_q  <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
`ifdef STABLE_CNT_SNAPSHOT_EN
            snap_hi_q   <= snap_hi_d;
            snap_vld_q  <= snap_vld_d;
`endif
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: rtl/stable_cnt_unit.sv
// Stable-counter service: prescaled free-running counter, TID register, N_PORTS read channels.
// STABLE_CNT_SNAPSHOT_EN enables per-channel VL/VH snapshot coherence in stable_cnt_port.
module stable_cnt_unit
    import stable_cnt_unit_pkg::*;
#(
    parameter int          N_PORTS = 2,
    parameter int          CNT_W   = 64,
    parameter int          DIV     = 1,
    parameter logic [31:0] TID_RST = 32'h0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cnt_en,
    input  logic                   tid_we,
    input  logic [31:0]            tid_wdata,
    output logic [31:0]            tid_rdata,
    input  logic [N_PORTS-1:0]     req_valid,
    input  logic [2*N_PORTS-1:0]   req_sel,
    output logic [N_PORTS-1:0]     req_ready,
    output logic [N_PORTS-1:0]     rsp_valid,
    output logic [32*N_PORTS-1:0]  rsp_data,
    output logic [N_PORTS-1:0]     rsp_err,
    input  logic [N_PORTS-1:0]     rsp_ready
);

    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      tid_q, tid_d;
    logic [63:0]      cnt_ext;

    always_comb begin
        pre_d = pre_q;
        cnt_d = cnt_q;
        tid_d = tid_we ? tid_wdata : tid_q;
        if (cnt_en) begin
            if (pre_q == PRE_W'(DIV - 1)) begin
                pre_d = '0;
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q <= '0;
            cnt_q <= '0;
            tid_q <= TID_RST;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
            tid_q <= tid_d;
        end
    end

    // Bits above CNT_W-1 read as zero on every channel.
    assign cnt_ext   = 64'(cnt_q);
    assign tid_rdata = tid_q;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        stable_cnt_port u_port (
            .clk       (clk),
            .reset     (reset),
            .cnt       (cnt_ext),
            .tid       (tid_q),
            .req_valid (req_valid[i]),
            .req_sel   (rdcnt_sel_e'(req_sel[2*i +: 2])),
            .req_ready (req_ready[i]),
            .rsp_valid (rsp_valid[i]),
            .rsp_data  (rsp_data[32*i +: 32]),
            .rsp_err   (rsp_err[i]),
            .rsp_ready (rsp_ready[i])
        );
    end

endmodule

// File: tb/tb_stable_cnt_unit.sv
// Directed bench for stable_cnt_unit with a per-channel expected-response scoreboard.
// Expectations follow STABLE_CNT_SNAPSHOT_EN when it is defined for the build.
module tb_stable_cnt_unit;
    import stable_cnt_unit_pkg::*;

    localparam logic [31:0] TID_A = 32'h0000_5A5A;
    localparam logic [31:0] TID_B = 32'h0000_3C3C;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, cnt_en, tid_we;
    logic [31:0] tid_wdata, tid_rdata;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_err, rsp_ready;
    logic [3:0]  req_sel;
    logic [63:0] rsp_data;

    logic        reset4, cnt_en4, tid_we4;
    logic [31:0] tid_wdata4, tid_rdata4;
    logic [0:0]  req_valid4, req_ready4, rsp_valid4, rsp_err4, rsp_ready4;
    logic [1:0]  req_sel4;
    logic [31:0] rsp_data4;

    exp_t sb [3][$];
    int   n_asserts = 0;
    int   n_fail    = 0;

    always #5 clk = ~clk;

    stable_cnt_unit #(.N_PORTS(2), .CNT_W(64), .DIV(1), .TID_RST(TID_A)) dut (
        .clk(clk), .reset(reset), .cnt_en(cnt_en), .tid_we(tid_we),
        .tid_wdata(tid_wdata), .tid_rdata(tid_rdata), .req_valid(req_valid),
        .req_sel(req_sel), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready)
    );

    stable_cnt_unit #(.N_PORTS(1), .CNT_W(40), .DIV(4), .TID_RST(TID_B)) dut4 (
        .clk(clk), .reset(reset4), .cnt_en(cnt_en4), .tid_we(tid_we4),
        .tid_wdata(tid_wdata4), .tid_rdata(tid_rdata4), .req_valid(req_valid4),
        .req_sel(req_sel4), .req_ready(req_ready4), .rsp_valid(rsp_valid4),
        .rsp_data(rsp_data4), .rsp_err(rsp_err4), .rsp_ready(rsp_ready4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input logic [31:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        sb[ch].push_back(x);
    endtask

    // Consumed responses are matched against the scoreboard in order.
    always @(negedge clk) begin
        exp_t x;
        for (int p = 0; p < 3; p++) begin
            logic        v, r, e;
            logic [31:0] d;
            if (p < 2) begin
                v = rsp_valid[p]; r = rsp_ready[p]; e = rsp_err[p]; d = rsp_data[32*p +: 32];
            end else begin
                v = rsp_valid4[0]; r = rsp_ready4[0]; e = rsp_err4[0]; d = rsp_data4;
            end
            if (v === 1'b1 && r === 1'b1) begin
                if (sb[p].size() == 0) begin
                    chk($sformatf("unexpected_rsp_ch%0d", p), 64'(v), 64'd0);
                end else begin
                    x = sb[p].pop_front();
                    chk($sformatf("rsp_data_ch%0d", p), 64'(d), 64'(x.data));
                    chk($sformatf("rsp_err_ch%0d", p), 64'(e), 64'(x.err));
                end
            end
        end
    end

    initial begin
        reset = 1'b1; cnt_en = 1'b1; tid_we = 1'b0; tid_wdata = '0;
        req_valid = '0; req_sel = '0; rsp_ready = 2'b11;
        reset4 = 1'b1; cnt_en4 = 1'b1; tid_we4 = 1'b0; tid_wdata4 = '0;
        req_valid4 = '0; req_sel4 = '0; rsp_ready4 = 1'b1;
        repeat (3) tick();

        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_data", rsp_data, 64'd0);
        chk("reset_rsp_err", 64'(rsp_err), 64'd0);
        chk("reset_tid", 64'(tid_rdata), 64'(TID_A));
        chk("reset_req_ready", 64'(req_ready), 64'd3);
        chk("reset_tid_dut4", 64'(tid_rdata4), 64'(TID_B));

        // Cycle 0 starts here; the counter reads 5 in cycle 5.
        reset = 1'b0;
        repeat (5) tick();
        req_valid[0] = 1'b1; req_sel[1:0] = RDCNT_SEL_VL; push(0, 32'd5, 1'b0);
        tick();
        chk("latency_rsp_valid0", 64'(rsp_valid[0]), 64'd1);
        req_sel[1:0] = RDCNT_SEL_VH; push(0, 32'd0, 1'b0);
        tick();
        req_valid[0] = 1'b0;
        tick();
        chk("idle_rsp_valid0", 64'(rsp_valid[0]), 64'd0);

        // Prescaler: 16 enabled cycles at DIV=4, then a freeze.
        reset4 = 1'b0;
        repeat (16) tick();
        cnt_en4 = 1'b0;
        repeat (10) tick();
        req_valid4[0] = 1'b1; req_sel4 = RDCNT_SEL_VL; push(2, 32'd4, 1'b0);
        tick();
        req_valid4[0] = 1'b0; cnt_en4 = 1'b1;
        repeat (3) tick();
        req_valid4[0] = 1'b1; req_sel4 = RDCNT_SEL_VL; push(2, 32'd4, 1'b0);
        tick();
        req_sel4 = RDCNT_SEL_VH; push(2, 32'd0, 1'b0);
        tick();
        req_sel4 = RDCNT_SEL_VL; push(2, 32'd5, 1'b0);
        tick();
        req_valid4[0] = 1'b0;
        tick();

        // Low-half carry between VL and VH.
        cnt_en = 1'b0;
        force dut.cnt_q = 64'h0000_0000_FFFF_FFFF;
        tick();
        release dut.cnt_q;
        cnt_en = 1'b1;
        req_valid[0] = 1'b1; req_sel[1:0] = RDCNT_SEL_VL; push(0, 32'hFFFF_FFFF, 1'b0);
        tick();
`ifdef STABLE_CNT_SNAPSHOT_EN
        req_sel[1:0] = RDCNT_SEL_VH; push(0, 32'd0, 1'b0);
`else
        req_sel[1:0] = RDCNT_SEL_VH; push(0, 32'd1, 1'b0);
`endif
        tick();
        req_valid[0] = 1'b0;
        tick();

        // Response hold on channel 1 with a pending request.
        req_valid[1] = 1'b1; req_sel[3:2] = RDCNT_SEL_ID; rsp_ready[1] = 1'b0;
        push(1, TID_A, 1'b0);
        tick();
        req_sel[3:2] = RDCNT_SEL_INV; push(1, 32'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("hold_req_ready1", 64'(req_ready[1]), 64'd0);
            chk("hold_rsp_valid1", 64'(rsp_valid[1]), 64'd1);
            chk("hold_rsp_data1", 64'(rsp_data[63:32]), 64'(TID_A));
            tick();
        end
        rsp_ready[1] = 1'b1;
        #1 chk("release_req_ready1", 64'(req_ready[1]), 64'd1);
        tick();
        chk("nobubble_rsp_valid1", 64'(rsp_valid[1]), 64'd1);
        chk("nobubble_rsp_err1", 64'(rsp_err[1]), 64'd1);
        req_valid[1] = 1'b0;
        tick();
        chk("drain_rsp_valid1", 64'(rsp_valid[1]), 64'd0);

        // TID write and same-cycle read.
        tid_we = 1'b1; tid_wdata = 32'h0000_00A5;
        req_valid[0] = 1'b1; req_sel[1:0] = RDCNT_SEL_ID; push(0, TID_A, 1'b0);
        chk("tid_old_same_cycle", 64'(tid_rdata), 64'(TID_A));
        tick();
        tid_we = 1'b0;
        chk("tid_new", 64'(tid_rdata), 64'h0000_00A5);
        push(0, 32'h0000_00A5, 1'b0);
        tick();
        req_valid[0] = 1'b0;
        tick();

        // Both channels read across the full-width wrap, then reset mid-response.
        cnt_en = 1'b0;
        force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        release dut.cnt_q;
        cnt_en = 1'b1;
        req_valid = 2'b11; req_sel = {RDCNT_SEL_VL, RDCNT_SEL_VL};
        push(0, 32'hFFFF_FFFF, 1'b0); push(1, 32'hFFFF_FFFF, 1'b0);
        tick();
        req_sel = {RDCNT_SEL_VH, RDCNT_SEL_VL};
        push(0, 32'd0, 1'b0);
`ifdef STABLE_CNT_SNAPSHOT_EN
        push(1, 32'hFFFF_FFFF, 1'b0);
`else
        push(1, 32'd0, 1'b0);
`endif
        tick();
        chk("pre_reset_rsp_valid", 64'(rsp_valid), 64'd3);
        reset = 1'b1; req_valid = 2'b00;
        tick();
        chk("post_reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("post_reset_rsp_data", rsp_data, 64'd0);
        chk("post_reset_rsp_err", 64'(rsp_err), 64'd0);
        chk("post_reset_tid", 64'(tid_rdata), 64'(TID_A));
        reset = 1'b0;
        repeat (2) tick();

        for (int c = 0; c < 3; c++)
            chk($sformatf("sb_drain_ch%0d", c), 64'(sb[c].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
